// File: rtl/qdiv_seq.sv
// Request sequencer in front of the serial Q-format sign-magnitude divider.
// Buffers operand pairs, runs one division at a time and bypasses divide-by-zero.
module qdiv_seq #(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_dividend,
    input  logic [N-1:0]            in_divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_quotient,
    output logic                    out_divzero,
    output logic [$clog2(DEPTH):0]  level,
    output logic [N-1:0]            div_dividend,
    output logic [N-1:0]            div_divisor,
    output logic                    div_start,
    input  logic [N-1:0]            div_quotient,
    input  logic                    div_complete
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || Q < 0 || Q > N - 2) begin : g_bad_params
        $error("qdiv_seq: DEPTH must be a power of two >= 2 and Q must fit in N-1 bits");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t        state;
    state_t        next_state;

    logic [N-1:0]  fifo_dividend [DEPTH];
    logic [N-1:0]  fifo_divisor  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [N-1:0]  head_dividend;
    logic [N-1:0]  head_divisor;
    logic          head_divzero;
    logic          zero_sign;
    logic [N-1:0]  captured;

    // in_ready comes only from the registered level, never from out_ready
    assign in_ready      = (level != FULL);
    assign push          = in_valid && in_ready;
    assign head_dividend = fifo_dividend[rd_ptr];
    assign head_divisor  = fifo_divisor[rd_ptr];
    assign head_divzero  = (head_divisor[N-2:0] == '0);
    assign zero_sign     = head_dividend[N-1] ^ head_divisor[N-1];
    assign captured      = (div_quotient[N-2:0] == '0) ? '0 : div_quotient;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_dividend[wr_ptr] <= in_dividend;
            fifo_divisor[wr_ptr]  <= in_divisor;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        div_start  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    next_state = head_divzero ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                div_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (div_complete) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result and divider operand registers; the divider itself has no reset,
    // so a fresh ISSUE is what discards any stale operation it still runs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_quotient <= '0;
            out_divzero  <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_divzero) begin
                            out_quotient <= {zero_sign, {(N-1){1'b1}}};
                            out_divzero  <= 1'b1;
                        end else begin
                            div_dividend <= head_dividend;
                            div_divisor  <= head_divisor;
                        end
                    end
                end
                WAIT: begin
                    if (div_complete) begin
                        out_quotient <= captured;
                        out_divzero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_seq.sv
// Bench for qdiv_seq: a timed divider stub, directed vectors, backpressure,
// reset mid-division and a randomized stream checked against a queue model.
module tb_qdiv_seq;

    localparam int Q     = 15;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [N-1:0]           in_dividend = '0;
    logic [N-1:0]           in_divisor = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [N-1:0]           out_quotient;
    logic                   out_divzero;
    logic [$clog2(DEPTH):0] level;
    logic [N-1:0]           div_dividend;
    logic [N-1:0]           div_divisor;
    logic                   div_start;
    logic [N-1:0]           div_quotient = '0;
    logic                   div_complete = 1'b0;

    qdiv_seq #(.Q(Q), .N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_divzero(out_divzero),
        .level(level),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_start(div_start), .div_quotient(div_quotient),
        .div_complete(div_complete)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
        end
    endtask

    task automatic reportFail(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Divider stand-in: no reset, restarts on every start, raises complete
    // N+Q-1 edges after sampling start, and returns un-normalised signs.
    logic [N-1:0] stub_a = '0;
    logic [N-1:0] stub_b = '0;
    int           stub_cnt = 0;
    logic         stub_busy = 1'b0;

    function automatic logic [N-1:0] stub_divide(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0]  num;
        logic [63:0]  den;
        logic [N-2:0] mag;
        num = 64'(a[N-2:0]) << Q;
        den = 64'(b[N-2:0]);
        mag = (den == 0) ? '0 : (N-1)'(num / den);
        return {a[N-1] ^ b[N-1], mag};
    endfunction

    always @(posedge clk) begin
        if (div_start) begin
            stub_busy    <= 1'b1;
            stub_cnt     <= 0;
            div_complete <= 1'b0;
            stub_a       <= div_dividend;
            stub_b       <= div_divisor;
        end else if (stub_busy) begin
            if (stub_cnt == N + Q - 2) begin
                stub_busy    <= 1'b0;
                div_complete <= 1'b1;
                div_quotient <= stub_divide(stub_a, stub_b);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    typedef struct packed {
        logic [N-1:0] q;
        logic         dz;
    } result_t;

    function automatic result_t ref_divide(input logic [N-1:0] a, input logic [N-1:0] b);
        result_t     r;
        logic [63:0] m;
        logic        s;
        s = a[N-1] ^ b[N-1];
        if (b[N-2:0] == '0) begin
            r.q  = {s, {(N-1){1'b1}}};
            r.dz = 1'b1;
        end else begin
            m    = ((64'(a[N-2:0]) * (64'd1 << Q)) / 64'(b[N-2:0])) % (64'd1 << (N - 1));
            r.dz = 1'b0;
            r.q  = (m == 0) ? '0 : {s, m[N-2:0]};
        end
        return r;
    endfunction

    result_t expect_q[$];
    int      accepted = 0;

    // Mid-cycle monitor: every accepted request queues its expected result,
    // every consumed result must match the oldest outstanding one
    always @(negedge clk) begin
        result_t e;
        if (rst) begin
            expect_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                expect_q.push_back(ref_divide(in_dividend, in_divisor));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (expect_q.size() == 0) begin
                    reportFail("stream_unrequested_result", out_quotient, 0);
                end else begin
                    e = expect_q.pop_front();
                    checkOutput("stream_quotient", out_quotient, e.q);
                    checkOutput("stream_divzero", out_divzero, e.dz);
                end
            end
        end
    end

    function automatic logic [N-1:0] rand_dividend();
        logic [N-2:0] mag;
        mag = (N-1)'($urandom() >> $urandom_range(1, 24));
        return {1'($urandom_range(0, 1)), mag};
    endfunction

    function automatic logic [N-1:0] rand_divisor(input bit allow_zero);
        logic [N-2:0] mag;
        mag = (N-1)'($urandom() >> $urandom_range(1, 28));
        if ((allow_zero && $urandom_range(0, 5) == 0) || (!allow_zero && mag == '0)) begin
            mag = allow_zero ? '0 : (N-1)'(1);
        end
        return {1'($urandom_range(0, 1)), mag};
    endfunction

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        step();
        in_valid    = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic         dz;
        int           lat;
        int           starts;
    } vec_t;

    vec_t vecs[8];

    task automatic runVector(input vec_t v, input int idx);
        int n;
        int starts;
        n      = 0;
        starts = 0;
        applyStimulus(v.a, v.b);
        while (!out_valid && n < 200) begin
            step();
            n++;
            if (div_start) starts++;
        end
        checkOutput($sformatf("vec%0d_latency", idx), n, v.lat);
        checkOutput($sformatf("vec%0d_quotient", idx), out_quotient, v.q);
        checkOutput($sformatf("vec%0d_divzero", idx), out_divzero, v.dz);
        checkOutput($sformatf("vec%0d_start_cycles", idx), starts, v.starts);
        if (!v.dz) begin
            checkOutput($sformatf("vec%0d_div_dividend", idx), div_dividend, v.a);
            checkOutput($sformatf("vec%0d_div_divisor", idx), div_divisor, v.b);
        end
        step();
        checkOutput($sformatf("vec%0d_released", idx), out_valid, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_quotient"}, out_quotient, 0);
        checkOutput({tag, "_out_divzero"}, out_divzero, 0);
        checkOutput({tag, "_div_start"}, div_start, 0);
        checkOutput({tag, "_div_dividend"}, div_dividend, 0);
        checkOutput({tag, "_div_divisor"}, div_divisor, 0);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_level"}, level, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        bit          stable;
        logic [N-1:0] held_q;
        vec_t        rv;

        vecs[0] = '{32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, 49, 1};
        vecs[1] = '{32'h80018000, 32'h00010000, 32'h8000C000, 1'b0, 49, 1};
        vecs[2] = '{32'h80000000, 32'h00010000, 32'h00000000, 1'b0, 49, 1};
        vecs[3] = '{32'h00008000, 32'h80020000, 32'h80002000, 1'b0, 49, 1};
        vecs[4] = '{32'h00018000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 0};
        vecs[5] = '{32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1, 0};
        vecs[6] = '{32'h80040000, 32'h00000001, 32'h00000000, 1'b0, 49, 1};
        vecs[7] = '{32'h00000003, 32'h00000002, 32'h0000C000, 1'b0, 49, 1};

        rst = 1'b1;
        step();
        step();
        checkResetState("reset");
        rst       = 1'b0;
        out_ready = 1'b1;
        step();

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i], i);
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid    = 1'b1;
            in_dividend = rand_dividend();
            in_divisor  = rand_divisor(1'b0);
            step();
        end
        in_valid = 1'b0;
        checkOutput("bp_accepted", accepted, DEPTH + 1);
        checkOutput("bp_level_full", level, DEPTH);
        checkOutput("bp_in_ready_low", in_ready, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        checkOutput("bp_first_result_valid", out_valid, 1);
        held_q = out_quotient;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!out_valid || out_quotient !== held_q || div_start || level != DEPTH) stable = 1'b0;
        end
        checkOutput("bp_hold_stable", stable, 1);
        out_ready = 1'b1;
        step();
        step();
        checkOutput("bp_level_after_pop", level, DEPTH - 1);
        checkOutput("bp_in_ready_resumed", in_ready, 1);
        accepted = 0;
        applyStimulus(rand_dividend(), rand_divisor(1'b1));
        checkOutput("bp_push_resumed", accepted, 1);
        n = 0;
        while ((expect_q.size() != 0 || out_valid) && n < 1000) begin
            step();
            n++;
        end
        checkOutput("bp_drained", expect_q.size(), 0);
        checkOutput("bp_level_empty", level, 0);

        $display("[TB] reset during wait");
        applyStimulus(32'h00018000, 32'h00010000);
        for (int i = 0; i < 22; i++) step();
        rst = 1'b1;
        step();
        checkResetState("wait_reset");
        rst = 1'b0;
        rv  = '{32'h00008000, 32'h80020000, 32'h80002000, 1'b0, 49, 1};
        runVector(rv, 99);

        $display("[TB] randomized stream");
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) == 0);
            in_dividend = rand_dividend();
            in_divisor  = rand_divisor(1'b1);
            out_ready   = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((expect_q.size() != 0 || out_valid) && n < 1000) begin
            step();
            n++;
        end
        checkOutput("random_drained", expect_q.size(), 0);
        checkOutput("random_level_empty", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
